// File: rtl/toi2s_pkg.sv
// Shared types and defaults for the multi-channel PWM block and its register-bank fields.
package toi2s_pkg;

    typedef enum logic {
        PWM_EDGE   = 1'b0,
        PWM_CENTER = 1'b1
    } pwm_mode_t;

    // Counter direction; in edge mode the counter always stays in CNT_UP.
    typedef enum logic {
        CNT_DOWN = 1'b0,
        CNT_UP   = 1'b1
    } cnt_dir_t;

    localparam int PWM_WIDTH      = 8;
    localparam int PWM_CHANNELS   = 4;
    localparam int PWM_PRESCALE_W = 8;

    typedef struct packed {
        logic [PWM_PRESCALE_W-1:0]                 prescale;
        logic                                      center_mode;
        logic                                      duty_load;
        logic [PWM_CHANNELS-1:0][PWM_WIDTH-1:0]    duty;
    } pwm_cfg_t;

endpackage

// File: rtl/pwm_multi_if.sv
// Config/output bundle between the register bank (master) and pwm_multi (slave).
interface pwm_multi_if import toi2s_pkg::*; #(
    parameter int WIDTH      = PWM_WIDTH,
    parameter int CHANNELS   = PWM_CHANNELS,
    parameter int PRESCALE_W = PWM_PRESCALE_W
);
    // No backpressure: duty_cycle is qualified by the one-cycle duty_load strobe and is
    // always accepted; the slave presents pwm_out/period_start as valid on every clock.
    logic                         enable;
    logic [PRESCALE_W-1:0]        prescale;
    logic                         center_mode;
    logic [CHANNELS*WIDTH-1:0]    duty_cycle;
    logic                         duty_load;
    logic [CHANNELS-1:0]          pwm_out;
    logic                         period_start;
    logic [WIDTH-1:0]             cnt_dbg;
    logic                         dir_up_dbg;

    modport master (
        output enable, prescale, center_mode, duty_cycle, duty_load,
        input  pwm_out, period_start, cnt_dbg, dir_up_dbg
    );

    modport slave (
        input  enable, prescale, center_mode, duty_cycle, duty_load,
        output pwm_out, period_start, cnt_dbg, dir_up_dbg
    );
endinterface

// File: rtl/pwm_multi_chan.sv
// One PWM channel: pending/active duty registers and the registered compare output.
module pwm_chan import toi2s_pkg::*; #(
    parameter int WIDTH = PWM_WIDTH
) (
    input  logic             clock_in,
    input  logic             reset,
    input  logic             i_enable,
    input  logic             i_duty_load,
    input  logic             i_load_active,
    input  logic [WIDTH-1:0] i_duty,
    input  logic [WIDTH-1:0] i_cnt,
    output logic             o_pwm
);
    logic [WIDTH-1:0] r_pending;
    logic [WIDTH-1:0] r_active;
    logic             r_pwm;

    always_ff @(posedge clock_in) begin
        if (reset) begin
            r_pending <= '0;
            r_active  <= '0;
            r_pwm     <= 1'b0;
        end else begin
            if (i_duty_load)
                r_pending <= i_duty;
            // A load landing on the swap clock bypasses pending so it is not lost for a period.
            if (i_load_active)
                r_active <= i_duty_load ? i_duty : r_pending;
            r_pwm <= i_enable & (i_cnt < r_active);
        end
    end

    assign o_pwm = r_pwm;
endmodule

// File: rtl/pwm_multi.sv
// Multi-channel PWM: shared prescaler, edge/centre counter and period boundary logic.
module pwm_multi import toi2s_pkg::*; #(
    parameter int WIDTH      = PWM_WIDTH,
    parameter int CHANNELS   = PWM_CHANNELS,
    parameter int PRESCALE_W = PWM_PRESCALE_W
) (
    input  logic       clock_in,
    input  logic       reset,
    pwm_multi_if.slave bus
);
    // MAX-1 is all ones with the LSB cleared.
    localparam logic [WIDTH-1:0] CNT_LAST = {{(WIDTH-1){1'b1}}, 1'b0};

    logic [PRESCALE_W-1:0] r_pcnt;
    logic [WIDTH-1:0]      r_cnt;
    cnt_dir_t              r_dir;
    pwm_mode_t             r_mode_act;
    logic                  r_en_d;
    logic                  r_period_start;

    logic                  w_tick;
    logic                  w_boundary;
    logic                  w_load_active;
    logic [PRESCALE_W-1:0] w_pcnt_nxt;
    logic [WIDTH-1:0]      w_cnt_nxt;
    cnt_dir_t              w_dir_nxt;
    logic [CHANNELS-1:0]   w_pwm;

    always_comb begin
        w_tick     = bus.enable && (r_pcnt == bus.prescale);
        w_pcnt_nxt = (r_pcnt >= bus.prescale) ? '0 : r_pcnt + 1'b1;
        w_cnt_nxt  = r_cnt;
        w_dir_nxt  = r_dir;
        w_boundary = 1'b0;
        if (w_tick) begin
            if (r_mode_act == PWM_EDGE) begin
                if (r_cnt == CNT_LAST) begin
                    w_cnt_nxt  = '0;
                    w_dir_nxt  = CNT_UP;
                    w_boundary = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end else if (r_dir == CNT_UP) begin
                // Turning at an end value holds cnt for a second tick.
                if (r_cnt == CNT_LAST)
                    w_dir_nxt = CNT_DOWN;
                else
                    w_cnt_nxt = r_cnt + 1'b1;
            end else begin
                if (r_cnt == '0) begin
                    w_dir_nxt  = CNT_UP;
                    w_boundary = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
        end
        w_load_active = w_boundary | ~bus.enable;
    end

    always_ff @(posedge clock_in) begin
        if (reset) begin
            r_pcnt         <= '0;
            r_cnt          <= '0;
            r_dir          <= CNT_UP;
            r_mode_act     <= PWM_EDGE;
            r_en_d         <= 1'b0;
            r_period_start <= 1'b0;
        end else if (!bus.enable) begin
            r_pcnt         <= '0;
            r_cnt          <= '0;
            r_dir          <= CNT_UP;
            r_mode_act     <= pwm_mode_t'(bus.center_mode);
            r_en_d         <= 1'b0;
            r_period_start <= 1'b0;
        end else begin
            r_pcnt         <= w_pcnt_nxt;
            r_cnt          <= w_cnt_nxt;
            r_dir          <= w_dir_nxt;
            if (w_boundary)
                r_mode_act <= pwm_mode_t'(bus.center_mode);
            r_en_d         <= 1'b1;
            r_period_start <= ~r_en_d | w_boundary;
        end
    end

    for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
        pwm_chan #(.WIDTH(WIDTH)) u_chan (
            .clock_in      (clock_in),
            .reset         (reset),
            .i_enable      (bus.enable),
            .i_duty_load   (bus.duty_load),
            .i_load_active (w_load_active),
            .i_duty        (bus.duty_cycle[g*WIDTH +: WIDTH]),
            .i_cnt         (r_cnt),
            .o_pwm         (w_pwm[g])
        );
    end

    assign bus.pwm_out      = w_pwm;
    assign bus.period_start = r_period_start;
    assign bus.cnt_dbg      = r_cnt;
    assign bus.dir_up_dbg   = (r_dir == CNT_UP);
endmodule
